// File: rtl/tcdm_interconnect_pkg.sv
// Shared constants and the request record used around TCDM bank ports.
package tcdm_interconnect_pkg;

   localparam int unsigned DefaultRespLat      = 1;
   localparam int unsigned DefaultAddrMemWidth = 12;
   localparam int unsigned DefaultDataWidth    = 32;
   localparam int unsigned DefaultBeWidth      = DefaultDataWidth / 8;

   // One bank-port request as seen by the interconnect at the default widths.
   typedef struct packed {
      logic                           wen;
      logic [DefaultBeWidth-1:0]      be;
      logic [DefaultAddrMemWidth-1:0] addr;
      logic [DefaultDataWidth-1:0]    wdata;
   } tcdm_req_t;

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Fixed-depth valid+data shift register that delays read responses.
module tcdm_resp_pipe #(
   parameter int unsigned Depth = 1,
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o
);

   logic             valid_q [Depth];
   logic [Width-1:0] data_q  [Depth];

   // Valid bits shift every cycle; reset drops whatever is in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) valid_q[i] <= 1'b0;
      end else begin
         valid_q[0] <= valid_i;
         for (int i = 1; i < Depth; i++) valid_q[i] <= valid_q[i-1];
      end
   end

   // Data travels alongside its valid bit; it is meaningless while valid is low.
   always_ff @(posedge clk_i) begin
      data_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) data_q[i] <= data_q[i-1];
   end

   assign valid_o = valid_q[Depth-1];
   assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_responder.sv
// Single TCDM bank: byte-write memory, fixed-latency reads, range error and
// saturating access counters.
module tcdm_bank_responder
   import tcdm_interconnect_pkg::*;
#(
   parameter int unsigned AddrMemWidth = 12,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned BeWidth      = DataWidth / 8,
   parameter int unsigned NumWords     = 2 ** AddrMemWidth,
   parameter int unsigned RespLat      = DefaultRespLat,
   parameter int unsigned CntWidth     = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [AddrMemWidth-1:0] add_i,
   input  logic                    wen_i,
   input  logic [DataWidth-1:0]    wdata_i,
   input  logic [BeWidth-1:0]      be_i,
   output logic [DataWidth-1:0]    rdata_o,
   input  logic                    stall_i,
   output logic                    err_o,
   output logic [CntWidth-1:0]     rd_cnt_o,
   output logic [CntWidth-1:0]     wr_cnt_o
);

   // One extra bit so NumWords == 2**AddrMemWidth is representable.
   localparam logic [AddrMemWidth:0] NumWordsExt = (AddrMemWidth + 1)'(NumWords);

   logic                 accept;
   logic                 in_range;
   logic                 load_ok;
   logic                 store_ok;
   logic [DataWidth-1:0] rd_word;
   logic                 pipe_valid;
   logic [DataWidth-1:0] pipe_data;
   logic [DataWidth-1:0] rdata_d, rdata_q;
   logic                 err_d, err_q;
   logic [CntWidth-1:0]  rd_cnt_d, rd_cnt_q;
   logic [CntWidth-1:0]  wr_cnt_d, wr_cnt_q;

   logic [DataWidth-1:0] mem_q [NumWords];

   // Grant is purely back-pressure; requests seen during reset are not acted on.
   assign gnt_o    = req_i & ~stall_i;
   assign accept   = req_i & gnt_o & ~rst_i;
   assign in_range = ({1'b0, add_i} < NumWordsExt);
   assign load_ok  = accept & ~wen_i & in_range;
   assign store_ok = accept &  wen_i & in_range;

   // Byte-masked store; memory contents survive reset.
   always_ff @(posedge clk_i) begin
      if (store_ok) begin
         for (int b = 0; b < BeWidth; b++) begin
            if (be_i[b]) mem_q[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   // Out-of-range loads still produce a (zero) response.
   assign rd_word = in_range ? mem_q[add_i] : '0;

   tcdm_resp_pipe #(
      .Depth (RespLat),
      .Width (DataWidth)
   ) u_resp_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (accept & ~wen_i),
      .data_i  (rd_word),
      .valid_o (pipe_valid),
      .data_o  (pipe_data)
   );

   // Next-state for read data hold, error pulse and saturating counters.
   always_comb begin
      rdata_d  = rdata_q;
      err_d    = accept & ~in_range;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (rst_i)           rdata_d = '0;
      else if (pipe_valid) rdata_d = pipe_data;
      if (load_ok  && !(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + CntWidth'(1);
      if (store_ok && !(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + CntWidth'(1);
   end

   // Output-side state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q  <= '0;
         err_q    <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // A due response is forwarded immediately; otherwise the last one is held.
   assign rdata_o  = rdata_d;
   assign err_o    = err_q;
   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed checks of tcdm_bank_responder at 32-bit data, 12 words, latency 2.
module tb_tcdm_bank_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        gnt;
   logic [3:0]  add;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        stall;
   logic        err;
   logic [3:0]  rd_cnt;
   logic [3:0]  wr_cnt;

   int vec  = 0;
   int miss = 0;

   tcdm_bank_responder #(
      .AddrMemWidth (4),
      .DataWidth    (32),
      .BeWidth      (4),
      .NumWords     (12),
      .RespLat      (2),
      .CntWidth     (4)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .gnt_o    (gnt),
      .add_i    (add),
      .wen_i    (wen),
      .wdata_i  (wdata),
      .be_i     (be),
      .rdata_o  (rdata),
      .stall_i  (stall),
      .err_o    (err),
      .rd_cnt_o (rd_cnt),
      .wr_cnt_o (wr_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      req = r; wen = w; add = a; wdata = d; be = b;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0;
      idle();
      tick();
      tick();
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_rdcnt", {28'd0, rd_cnt}, 32'd0);
      check("rst_wrcnt", {28'd0, wr_cnt}, 32'd0);
      rst = 1'b0;

      // Full-word store then byte-0 merge, read back after two cycles
      drive(1, 1, 4'd3, 32'hDEADBEEF, 4'hF); tick();
      drive(1, 1, 4'd3, 32'h000000AA, 4'h1); tick();
      drive(1, 0, 4'd3, 32'd0, 4'h0);
      #1 check("load_gnt", {31'd0, gnt}, 32'd1);
      tick();
      idle();
      check("lat_not_early", rdata, 32'd0);
      tick();
      check("byte_merge", rdata, 32'hDEADBEAA);
      check("merge_wrcnt", {28'd0, wr_cnt}, 32'd2);
      check("merge_rdcnt", {28'd0, rd_cnt}, 32'd1);
      check("merge_err", {31'd0, err}, 32'd0);

      // Stores and stalled cycles leave rdata untouched
      drive(1, 1, 4'd5, 32'h00000055, 4'hF); tick();
      drive(1, 0, 4'd6, 32'd0, 4'h0); stall = 1'b1;
      #1 check("stall_gnt", {31'd0, gnt}, 32'd0);
      tick();
      stall = 1'b0; idle();
      tick();
      check("hold_rdata", rdata, 32'hDEADBEAA);
      check("hold_wrcnt", {28'd0, wr_cnt}, 32'd3);
      check("hold_rdcnt", {28'd0, rd_cnt}, 32'd1);

      // Back-to-back loads return on consecutive cycles
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 4'(i), 32'h10 + 32'(i), 4'hF);
         tick();
      end
      drive(1, 0, 4'd0, 32'd0, 4'h0); tick();
      drive(1, 0, 4'd1, 32'd0, 4'h0); tick();
      check("b2b_0", rdata, 32'h10);
      drive(1, 0, 4'd2, 32'd0, 4'h0); tick();
      check("b2b_1", rdata, 32'h11);
      idle(); tick();
      check("b2b_2", rdata, 32'h12);
      tick();
      check("b2b_hold", rdata, 32'h12);
      check("b2b_rdcnt", {28'd0, rd_cnt}, 32'd4);
      check("b2b_wrcnt", {28'd0, wr_cnt}, 32'd6);

      // Store with no byte enables counts but changes nothing
      drive(1, 1, 4'd0, 32'hFFFFFFFF, 4'h0); tick();
      idle();
      check("be0_wrcnt", {28'd0, wr_cnt}, 32'd7);
      drive(1, 0, 4'd0, 32'd0, 4'h0); tick();
      idle(); tick();
      check("be0_data", rdata, 32'h10);

      // Grant withheld for three stalled cycles, then one acceptance
      do_reset();
      check("rst2_rdcnt", {28'd0, rd_cnt}, 32'd0);
      check("rst2_rdata", rdata, 32'd0);
      drive(1, 0, 4'd5, 32'd0, 4'h0); stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("stall_gnt%0d", i), {31'd0, gnt}, 32'd0);
         tick();
      end
      stall = 1'b0;
      #1 check("unstall_gnt", {31'd0, gnt}, 32'd1);
      tick();
      stall = 1'b1;
      tick();
      check("inflight_stall_data", rdata, 32'h55);
      stall = 1'b0; idle();
      check("stall_rdcnt", {28'd0, rd_cnt}, 32'd1);

      // Out-of-range store and load
      do_reset();
      drive(1, 0, 4'd5, 32'd0, 4'h0); tick();
      idle(); tick();
      check("oor_pre", rdata, 32'h55);
      drive(1, 1, 4'd13, 32'hFFFFFFFF, 4'hF); tick();
      check("oor_st_err", {31'd0, err}, 32'd1);
      drive(1, 0, 4'd14, 32'd0, 4'h0); tick();
      check("oor_ld_err", {31'd0, err}, 32'd1);
      idle(); tick();
      check("oor_err_end", {31'd0, err}, 32'd0);
      check("oor_ld_zero", rdata, 32'd0);
      check("oor_rdcnt", {28'd0, rd_cnt}, 32'd1);
      check("oor_wrcnt", {28'd0, wr_cnt}, 32'd0);
      drive(1, 0, 4'd5, 32'd0, 4'h0); tick();
      idle(); tick();
      check("oor_mem_kept", rdata, 32'h55);

      // Reset while a load is in flight
      do_reset();
      drive(1, 0, 4'd3, 32'd0, 4'h0); tick();
      idle(); rst = 1'b1; tick();
      rst = 1'b0;
      check("flush_rdata", rdata, 32'd0);
      check("flush_rdcnt", {28'd0, rd_cnt}, 32'd0);
      check("flush_wrcnt", {28'd0, wr_cnt}, 32'd0);
      tick(); tick();
      check("flush_no_resp", rdata, 32'd0);

      // Requests during reset are granted but ignored
      rst = 1'b1;
      drive(1, 1, 4'd3, 32'd0, 4'hF);
      #1 check("rst_req_gnt", {31'd0, gnt}, 32'd1);
      tick();
      rst = 1'b0; idle();
      check("rst_req_wrcnt", {28'd0, wr_cnt}, 32'd0);
      tick();
      check("rst_req_err", {31'd0, err}, 32'd0);
      drive(1, 0, 4'd3, 32'd0, 4'h0); tick();
      idle(); tick();
      check("rst_req_mem", rdata, 32'hDEADBEAA);

      // Read counter saturates at 4'hF
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 4'd0, 32'd0, 4'h0);
         tick();
         if (i == 13) check("sat_14", {28'd0, rd_cnt}, 32'd14);
      end
      idle();
      check("sat_final", {28'd0, rd_cnt}, 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter AddrMemWidth, default 12, word-address bits per bank.
REQ-002 SHALL have parameter DataWidth, default 32, word width.
REQ-003 SHALL have parameter BeWidth, default DataWidth/8, byte-enable width.
REQ-004 SHALL have parameter NumWords, default 2**AddrMemWidth, implemented words; legal range 1..2**AddrMemWidth.
REQ-005 SHALL have parameter RespLat, default 1, read latency in cycles; legal range >=1.
REQ-006 SHALL have parameter CntWidth, default 32, performance counter width.
REQ-007 Ports, one per line: name, direction, width, meaning:
- clk_i  in  1  single clock; all logic is rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  request from the interconnect bank port.
- gnt_o  out  1  grant; request accepted this cycle.
- add_i  in  AddrMemWidth  word address within bank.
- wen_i  in  1  1 = store, 0 = load.
- wdata_i  in  DataWidth  write data.
- be_i  in  BeWidth  byte enables.
- rdata_o  out  DataWidth  read data.
- stall_i  in  1  back-pressure injection; 1 withholds grant.
- err_o  out  1  one-cycle pulse on a granted out-of-range access.
- rd_cnt_o  out  CntWidth  granted in-range loads.
- wr_cnt_o  out  CntWidth  granted in-range stores.

Function
REQ-008 gnt_o SHALL be combinational: req_i & ~stall_i. No other dependence.
REQ-009 Acceptance SHALL be the cycle where req_i & gnt_o; at most one access per cycle.
REQ-010 Accepted in-range store SHALL update memory at that clock edge, byte i written only where be_i[i]=1.
REQ-011 Accepted in-range load SHALL present word add_i on rdata_o exactly RespLat cycles after acceptance, through a RespLat-deep pipeline of (valid, data).
REQ-012 Data SHALL be sampled from memory at acceptance. A store accepted in cycle t SHALL be visible to a load accepted in cycle t+1.
REQ-013 rdata_o SHALL hold its last returned value when no read response is due. Stores and stalled cycles SHALL NOT change it.
REQ-014 Out-of-range access SHALL leave memory unchanged, and SHALL NOT increment counters. Out of range means add_i >= NumWords.
REQ-015 Out-of-range load SHALL still return data: rdata_o = 0 after RespLat cycles.
REQ-016 err_o SHALL pulse high for one cycle, registered, in the cycle after acceptance of any out-of-range access.
REQ-017 Back-to-back accepted loads SHALL each return in consecutive cycles, with full throughput and no bubbles.
REQ-018 rd_cnt_o and wr_cnt_o SHALL increment by 1 per qualifying acceptance and SHALL saturate at all-ones, never wrapping.
REQ-019 stall_i asserted while a read is in flight SHALL NOT delay or drop that response.
REQ-020 be_i = 0 on a store SHALL count as a write but modify no byte.

Reset
REQ-021 On rst_i=1 at a clock edge, the following SHALL clear to 0: rdata_o, err_o, rd_cnt_o, wr_cnt_o, all pipeline valid bits.
REQ-022 Memory contents SHALL NOT be reset. Reads of never-written words are undefined (X) in simulation.
REQ-023 Reads in flight at reset SHALL be discarded, and rdata_o SHALL remain 0 until the next post-reset response.
REQ-024 Requests presented during reset cycles SHALL be ignored: no memory write, no counter update, no response. gnt_o still follows REQ-008.

Structure
REQ-025 Shared constants and typedefs SHALL live in tcdm_interconnect_pkg: default RespLat, and a request struct {wen, be, addr, wdata}.
REQ-026 The latency line SHALL be one sub-module, tcdm_resp_pipe: a parameterized depth/width valid+data shift register with synchronous reset.
REQ-027 Memory SHALL be an inferred single-port array of NumWords x DataWidth with byte-write.

Verification (DataWidth=32, AddrMemWidth=4, NumWords=12, RespLat=2)
REQ-028 Store 0xDEADBEEF at addr 3 with be=0xF, then store 0x000000AA at addr 3 with be=0x1, then load addr 3 -> rdata_o=0xDEADBEAA exactly 2 cycles after load grant; wr_cnt_o=2, rd_cnt_o=1.
REQ-029 Loads to addrs 0,1,2 in consecutive cycles, preloaded 0x10/0x11/0x12 -> rdata_o = 0x10, 0x11, 0x12 in cycles t+2, t+3, t+4.
REQ-030 req_i=1 with stall_i=1 for 3 cycles, then stall_i=0 -> gnt_o=0 for 3 cycles, single acceptance after, rd_cnt_o=1.
REQ-031 Store to addr 13 and load from addr 14 -> err_o pulses once per access, memory unchanged, load returns 0, counters unchanged.
REQ-032 Load accepted, then rst_i asserted the next cycle -> no response emerges, rdata_o=0, counters=0.
REQ-033 With CntWidth=4, 20 in-range loads -> rd_cnt_o saturates at 0xF.
